// File: rtl/serial_loader.sv
// Serial boot loader: receives an 8N1 program image on RxD, writes it into instruction
// memory and releases the CPU once the checksum matches. Optional: SERIAL_LOADER_TIMEOUT_EN.
module serial_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 10,
    parameter int TIMEOUT_CLKS = 50000000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              RxD,
    output logic [ADDR_W-1:0] imAddr,
    output logic [31:0]       imData,
    output logic              imWe,
    output logic              cpuHold,
    output logic              loadDone,
    output logic              loadError,
    output logic              busy
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [16:0]      MAX_WORDS = 17'(2 ** ADDR_W);
    localparam logic [7:0]       MAGIC     = 8'hA5;

    if (CLKS_PER_BIT < 4 || ADDR_W < 1 || ADDR_W > 16 || TIMEOUT_CLKS < 1) begin : g_bad_params
        $error("serial_loader: unsupported parameter values");
    end

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        P_WAIT_MAGIC,
        P_CNT_LO,
        P_CNT_HI,
        P_DATA,
        P_CSUM,
        P_DONE
    } pr_state_t;

    logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             byte_valid;
    logic             frame_err;

    pr_state_t         pr_state_q, pr_state_d;
    logic [15:0]       count_q, count_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        acc_q, acc_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_data_q, im_data_d;
    logic              im_we_q, im_we_d;
    logic              load_done_q, load_done_d;
    logic              load_error_q, load_error_d;
    logic              busy_q, busy_d;
    logic              fail;
    logic [16:0]       word_count;
    logic              word_last;
    logic              timeout_hit;

    // RxD is asynchronous; the extra prev flop only serves start-edge detection
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= RxD;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rx_state_q <= RX_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        clk_cnt_d  = clk_cnt_q + CNT_W'(1);
        bit_idx_d  = bit_idx_q;
        rx_shift_d = rx_shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                if (rxd_prev_q && !rxd_sync_q) begin
                    rx_state_d = RX_START;
                    bit_idx_d  = '0;
                end
            end
            RX_START: begin
                // A line that is high again mid start bit was only a glitch
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d  = '0;
                    rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d  = '0;
                    rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
                    bit_idx_d  = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    byte_valid = rxd_sync_q;
                    frame_err  = !rxd_sync_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

`ifdef SERIAL_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);

    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end

    always_comb begin
        idle_cnt_d  = '0;
        timeout_hit = 1'b0;
        if (busy_q && !byte_valid) begin
            idle_cnt_d  = idle_cnt_q + TO_W'(1);
            timeout_hit = (idle_cnt_q == TO_W'(TIMEOUT_CLKS - 1));
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pr_state_q   <= P_WAIT_MAGIC;
            count_q      <= '0;
            byte_idx_q   <= '0;
            word_idx_q   <= '0;
            word_q       <= '0;
            acc_q        <= '0;
            im_addr_q    <= '0;
            im_data_q    <= '0;
            im_we_q      <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            pr_state_q   <= pr_state_d;
            count_q      <= count_d;
            byte_idx_q   <= byte_idx_d;
            word_idx_q   <= word_idx_d;
            word_q       <= word_d;
            acc_q        <= acc_d;
            im_addr_q    <= im_addr_d;
            im_data_q    <= im_data_d;
            im_we_q      <= im_we_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            busy_q       <= busy_d;
        end
    end

    assign word_last = (16'(word_idx_q) == count_q - 16'd1);

    always_comb begin
        pr_state_d   = pr_state_q;
        count_d      = count_q;
        byte_idx_d   = byte_idx_q;
        word_idx_d   = word_idx_q;
        word_d       = word_q;
        acc_d        = acc_q;
        im_addr_d    = im_addr_q;
        im_data_d    = im_data_q;
        im_we_d      = 1'b0;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
        busy_d       = busy_q;
        fail         = 1'b0;
        word_count   = {1'b0, rx_shift_q, count_q[7:0]};
        case (pr_state_q)
            P_WAIT_MAGIC: begin
                if (byte_valid && rx_shift_q == MAGIC) begin
                    load_error_d = 1'b0;
                    busy_d       = 1'b1;
                    byte_idx_d   = '0;
                    word_idx_d   = '0;
                    acc_d        = '0;
                    pr_state_d   = P_CNT_LO;
                end
            end
            P_CNT_LO: begin
                if (byte_valid) begin
                    count_d[7:0] = rx_shift_q;
                    pr_state_d   = P_CNT_HI;
                end
            end
            P_CNT_HI: begin
                if (byte_valid) begin
                    count_d[15:8] = rx_shift_q;
                    if (word_count == 17'd0 || word_count > MAX_WORDS) begin
                        fail = 1'b1;
                    end else begin
                        pr_state_d = P_DATA;
                    end
                end
            end
            P_DATA: begin
                // Bytes enter from the top so the first one ends up in bits 7:0
                if (byte_valid) begin
                    word_d     = {rx_shift_q, word_q[31:8]};
                    acc_d      = acc_q ^ rx_shift_q;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        im_we_d    = 1'b1;
                        im_addr_d  = word_idx_q;
                        im_data_d  = word_d;
                        word_idx_d = word_idx_q + ADDR_W'(1);
                        if (word_last) begin
                            pr_state_d = P_CSUM;
                        end
                    end
                end
            end
            P_CSUM: begin
                if (byte_valid) begin
                    if (rx_shift_q == acc_q) begin
                        load_done_d = 1'b1;
                        busy_d      = 1'b0;
                        pr_state_d  = P_DONE;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            P_DONE: begin
                pr_state_d = P_DONE;
            end
            default: pr_state_d = P_WAIT_MAGIC;
        endcase
        if (frame_err && pr_state_q != P_WAIT_MAGIC && pr_state_q != P_DONE) begin
            fail = 1'b1;
        end
        if (timeout_hit) begin
            fail = 1'b1;
        end
        // Already written words are left in memory; only the attempt is abandoned
        if (fail) begin
            load_error_d = 1'b1;
            busy_d       = 1'b0;
            pr_state_d   = P_WAIT_MAGIC;
        end
    end

    assign imAddr    = im_addr_q;
    assign imData    = im_data_q;
    assign imWe      = im_we_q;
    assign cpuHold   = !load_done_q;
    assign loadDone  = load_done_q;
    assign loadError = load_error_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_loader.sv
// Self-checking bench for serial_loader: serial byte driver, stream-level reference
// model that predicts memory writes and status flags, per-cycle write comparison.
module tb_serial_loader;

   localparam int CPB = 16;
   localparam int AW  = 10;
   localparam int TO  = 10000;

   typedef logic [7:0] byte_q_t[$];
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          RxD;
   logic [AW-1:0] imAddr;
   logic [31:0]   imData;
   logic          imWe;
   logic          cpuHold;
   logic          loadDone;
   logic          loadError;
   logic          busy;

   int  compared   = 0;
   int  mismatched = 0;
   wr_t expWr[$];
   bit  mdlDone, mdlError, mdlBusy;

   serial_loader #(
      .CLKS_PER_BIT(CPB),
      .ADDR_W      (AW),
      .TIMEOUT_CLKS(TO)
   ) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .RxD      (RxD),
      .imAddr   (imAddr),
      .imData   (imData),
      .imWe     (imWe),
      .cpuHold  (cpuHold),
      .loadDone (loadDone),
      .loadError(loadError),
      .busy     (busy)
   );

   // 10 time-unit clock period
   always #5 Clock = ~Clock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Every stimulus cycle passes through here: each imWe pulse must match the next predicted write
   task automatic tick();
      wr_t w;
      @(negedge Clock);
      if (imWe === 1'b1) begin
         if (expWr.size() == 0) begin
            checkOutput("unexpected_imWe", {22'd0, imAddr}, 32'hFFFF_FFFF);
         end else begin
            w = expWr.pop_front();
            checkOutput("imAddr", {22'd0, imAddr}, {22'd0, w.addr});
            checkOutput("imData", imData, w.data);
         end
      end else if (imWe !== 1'b0) begin
         checkOutput("imWe_known", {31'd0, imWe}, 32'd0);
      end
   endtask

   task automatic sendByte(input logic [7:0] b, input logic stopBit);
      RxD = 1'b0;
      repeat (CPB) tick();
      for (int k = 0; k < 8; k++) begin
         RxD = b[k];
         repeat (CPB) tick();
      end
      RxD = stopBit;
      repeat (CPB) tick();
      RxD = 1'b1;
      repeat ($urandom_range(2, 20)) tick();
   endtask

   function automatic int take(input byte_q_t b, input int bad, inout int i, output logic [7:0] v);
      v = 8'h00;
      if (i >= b.size()) return 2;
      v = b[i];
      i++;
      if (i - 1 == bad) return 1;
      return 0;
   endfunction

   task automatic failAttempt();
      mdlError = 1'b1;
      mdlBusy  = 1'b0;
   endtask

   // Stream-level parse: magic, 16-bit count, N little-endian words, XOR checksum
   task automatic modelStream(input byte_q_t b, input int bad);
      int         i = 0;
      int         st;
      int         n;
      bit         abort;
      logic [7:0] v, lo, hi, acc;
      logic [31:0] w;
      while (i < b.size() && !mdlDone) begin
         st = take(b, bad, i, v);
         if (st != 0 || v != 8'hA5) continue;
         mdlError = 1'b0;
         mdlBusy  = 1'b1;
         st = take(b, bad, i, lo);
         if (st == 2) return;
         if (st == 1) begin failAttempt(); continue; end
         st = take(b, bad, i, hi);
         if (st == 2) return;
         if (st == 1) begin failAttempt(); continue; end
         n = int'({hi, lo});
         if (n == 0 || n > 2 ** AW) begin failAttempt(); continue; end
         acc   = 8'h00;
         abort = 1'b0;
         for (int wi = 0; wi < n && !abort; wi++) begin
            w = 32'h0;
            for (int k = 0; k < 4 && !abort; k++) begin
               st = take(b, bad, i, v);
               if (st == 2) return;
               if (st == 1) begin
                  failAttempt();
                  abort = 1'b1;
               end else begin
                  w[8*k +: 8] = v;
                  acc = acc ^ v;
               end
            end
            if (!abort) expWr.push_back(wr_t'{wi[AW-1:0], w});
         end
         if (abort) continue;
         st = take(b, bad, i, v);
         if (st == 2) return;
         if (st == 1 || v != acc) begin failAttempt(); continue; end
         mdlDone = 1'b1;
         mdlBusy = 1'b0;
      end
   endtask

   task automatic sendStream(input byte_q_t b, input int bad, input int glitchIdx);
      for (int i = 0; i < b.size(); i++) begin
         if (i == glitchIdx) begin
            RxD = 1'b0;
            repeat (3) tick();
            RxD = 1'b1;
            repeat (2 * CPB) tick();
         end
         sendByte(b[i], (i == bad) ? 1'b0 : 1'b1);
      end
      repeat (4) tick();
   endtask

   task automatic applyStimulus(input byte_q_t b, input int bad, input int glitchIdx);
      modelStream(b, bad);
      sendStream(b, bad, glitchIdx);
   endtask

   task automatic checkFlags(input string tag);
      checkOutput({tag, "_loadDone"},  {31'd0, loadDone},  {31'd0, mdlDone});
      checkOutput({tag, "_loadError"}, {31'd0, loadError}, {31'd0, mdlError});
      checkOutput({tag, "_busy"},      {31'd0, busy},      {31'd0, mdlBusy});
      checkOutput({tag, "_cpuHold"},   {31'd0, cpuHold},   {31'd0, !mdlDone});
      checkOutput({tag, "_writesLeft"}, expWr.size(), 32'd0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_imAddr"},    {22'd0, imAddr},     32'd0);
      checkOutput({tag, "_imData"},    imData,              32'd0);
      checkOutput({tag, "_imWe"},      {31'd0, imWe},       32'd0);
      checkOutput({tag, "_cpuHold"},   {31'd0, cpuHold},    32'd1);
      checkOutput({tag, "_loadDone"},  {31'd0, loadDone},   32'd0);
      checkOutput({tag, "_loadError"}, {31'd0, loadError},  32'd0);
      checkOutput({tag, "_busy"},      {31'd0, busy},       32'd0);
   endtask

   task automatic doReset();
      Reset = 1'b1;
      repeat (3) tick();
      Reset = 1'b0;
      mdlDone  = 1'b0;
      mdlError = 1'b0;
      mdlBusy  = 1'b0;
      expWr.delete();
      tick();
   endtask

   initial begin
      byte_q_t goodS, badS, s;
      logic [7:0] acc, g;
      int n;
      int waited;

      RxD   = 1'b1;
      Reset = 1'b1;
      mdlDone  = 1'b0;
      mdlError = 1'b0;
      mdlBusy  = 1'b0;
      repeat (5) tick();
      checkResetValues("reset");
      doReset();

      goodS = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
      badS  = goodS;
      badS[11] = 8'h2B;

      $display("[TB] bad checksum stream with a start-bit glitch inside the data");
      applyStimulus(badS, -1, 5);
      checkFlags("badCsum");
      checkOutput("badCsum_loadError_lit", {31'd0, loadError}, 32'd1);

      $display("[TB] count bounds");
      s = '{8'hA5, 8'h00, 8'h00};
      applyStimulus(s, -1, -1);
      checkFlags("countZero");
      s = '{8'hA5, 8'h01, 8'h04};
      applyStimulus(s, -1, -1);
      checkFlags("countBig");
      checkOutput("countBig_loadError_lit", {31'd0, loadError}, 32'd1);

      $display("[TB] framing error on the third data byte");
      s = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
      applyStimulus(s, 5, -1);
      checkFlags("frameErr");

      $display("[TB] framing error on a byte while waiting for magic");
      doReset();
      s = '{8'hA5};
      applyStimulus(s, 0, -1);
      checkFlags("frameIdle");

      $display("[TB] randomized loads");
      for (int r = 0; r < 6; r++) begin
         s.delete();
         for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
            g = 8'($urandom_range(0, 255));
            s.push_back((g == 8'hA5) ? 8'h5A : g);
         end
         n = int'($urandom_range(1, 4));
         s.push_back(8'hA5);
         s.push_back(8'(n));
         s.push_back(8'h00);
         acc = 8'h00;
         for (int k = 0; k < 4 * n; k++) begin
            g = 8'($urandom_range(0, 255));
            acc = acc ^ g;
            s.push_back(g);
         end
         s.push_back((r == 5) ? acc : (acc ^ 8'($urandom_range(1, 255))));
         applyStimulus(s, -1, -1);
         checkFlags($sformatf("rand%0d", r));
      end
      s = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
      applyStimulus(s, -1, -1);
      checkFlags("randAfterDone");

      $display("[TB] reset in the middle of a word");
      doReset();
      s = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};
      applyStimulus(s, -1, -1);
      checkFlags("preReset");
      Reset = 1'b1;
      tick();
      tick();
      checkResetValues("midReset");
      Reset = 1'b0;
      mdlDone  = 1'b0;
      mdlError = 1'b0;
      mdlBusy  = 1'b0;
      expWr.delete();
      repeat (300) tick();
      checkResetValues("afterReset");

      $display("[TB] literal bad then good image");
      applyStimulus(badS, -1, -1);
      checkFlags("litBad");
      modelStream(goodS, -1);
      checkOutput("pin_nWrites", expWr.size(), 32'd2);
      checkOutput("pin_w0_addr", {22'd0, expWr[0].addr}, 32'd0);
      checkOutput("pin_w0_data", expWr[0].data, 32'h1234_5678);
      checkOutput("pin_w1_addr", {22'd0, expWr[1].addr}, 32'd1);
      checkOutput("pin_w1_data", expWr[1].data, 32'hDEAD_BEEF);
      sendStream(goodS, -1, -1);
      checkFlags("litGood");
      checkOutput("litGood_loadDone_lit",  {31'd0, loadDone},  32'd1);
      checkOutput("litGood_cpuHold_lit",   {31'd0, cpuHold},   32'd0);
      checkOutput("litGood_loadError_lit", {31'd0, loadError}, 32'd0);
      applyStimulus(goodS, -1, -1);
      checkFlags("litExtra");

      $display("[TB] stalled load");
      doReset();
      s = '{8'hA5, 8'h01, 8'h00};
      applyStimulus(s, -1, -1);
      checkFlags("stallStart");
`ifdef SERIAL_LOADER_TIMEOUT_EN
      waited = 0;
      while (loadError !== 1'b1 && waited < TO + 100) begin
         tick();
         waited++;
      end
      checkOutput("timeout_loadError", {31'd0, loadError}, 32'd1);
      checkOutput("timeout_busy",      {31'd0, busy},      32'd0);
      checkOutput("timeout_cpuHold",   {31'd0, cpuHold},   32'd1);
`else
      waited = 0;
      repeat (3000) begin
         tick();
         waited++;
      end
      checkOutput("stall_busy",      {31'd0, busy},      32'd1);
      checkOutput("stall_loadError", {31'd0, loadError}, 32'd0);
      checkOutput("stall_waited",    waited,             32'd3000);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/serial_loader.md
Name: serial_loader

Overview:
- Serial boot loader sitting upstream of the CPU's instruction memory write port.
- Receives a program image over RS-232 (8N1) on RxD, assembles little-endian 32-bit words, and writes them sequentially into instruction memory from address 0.
- Holds the CPU in reset until an image loads with a valid checksum, then releases it.

Parameters:
- CLKS_PER_BIT, 434, Clock cycles per serial bit (50 MHz / 115200).
- ADDR_W, 10, instruction memory address width; maximum image is 2**ADDR_W words.
- TIMEOUT_CLKS, 50000000, inter-byte idle limit (used only with the optional feature).

Ports:
- Clock  in  1  50 MHz board clock
- Reset  in  1  reset
- RxD  in  1  raw serial input, idle high, asynchronous
- imAddr  out  ADDR_W  instruction memory write address
- imData  out  32  instruction memory write data
- imWe  out  1  one-cycle write strobe
- cpuHold  out  1  high = CPU held in reset
- loadDone  out  1  image loaded and verified (sticky until Reset)
- loadError  out  1  last load attempt failed
- busy  out  1  high between accepted magic byte and end of attempt

Behaviour:
- Reset: Reset is synchronous, active-high, on Clock.
  - Reset values: imAddr=0, imData=0, imWe=0, cpuHold=1, loadDone=0, loadError=0, busy=0.
  - Reset also forces the RX FSM to IDLE and the protocol FSM to WAIT_MAGIC.
  - Reset mid-load abandons the load; no further imWe pulses.
- RX synchroniser: RxD passes through 2 flip-flops before any use.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a synchronised falling edge moves to START with the bit counter cleared.
  - START: sample at CLKS_PER_BIT/2. If the line is high, treat it as a glitch and return to IDLE, no error.
  - DATA: 8 samples spaced CLKS_PER_BIT apart, LSB first.
  - STOP: sample after a further CLKS_PER_BIT. 1 = byte valid (one-cycle internal strobe). 0 = framing error.
- Protocol FSM (WAIT_MAGIC, CNT_LO, CNT_HI, DATA, CSUM, DONE):
  - WAIT_MAGIC: non-0xA5 bytes are ignored. 0xA5 clears loadError, sets busy, clears the byte index, word index and XOR accumulator.
  - CNT_LO / CNT_HI: 16-bit word count N, little-endian. N=0 or N>2**ADDR_W means error.
  - DATA: bytes shift into a 32-bit word, little-endian (first byte = bits 7:0), each byte XORed into the accumulator.
    - The cycle after the 4th byte of a word: imWe=1 for exactly one cycle, imAddr = word index, imData = word.
    - imAddr and imData hold afterwards; the word index then increments.
    - After word N-1 is written, go to CSUM.
  - CSUM: the received byte is compared with the accumulator (XOR of data bytes only; magic and count excluded). Match → DONE. Mismatch → error.
  - DONE: loadDone=1, cpuHold=0 and busy=0 from the cycle after the checksum byte strobe. All further RX traffic is ignored until Reset.
  - Error (any state past WAIT_MAGIC, including a framing error): loadError=1, busy=0, cpuHold stays 1, return to WAIT_MAGIC. Words already written stay in memory.
  - Framing error in WAIT_MAGIC: byte is dropped, no flag.
- Simultaneous events: Reset takes priority over everything. An imWe pulse and the next byte strobe never coincide, since bytes are at least 10*CLKS_PER_BIT apart.

Optional Feature:
- Macro: SERIAL_LOADER_TIMEOUT_EN.
- Defined:
  - A counter restarts on every valid byte strobe while busy.
  - If it reaches TIMEOUT_CLKS before the next byte, take the error path: loadError=1, return to WAIT_MAGIC.
- Undefined: no counter, and a stalled load waits forever.

Test Plan:
- Byte RX: drive 0x5A at 434 clk/bit. One internal strobe, data 0x5A. Glitch start (low for 100 clks) → no strobe.
- Good load: A5 02 00 78 56 34 12 EF BE AD DE 2A.
  - imWe pulses with (0, 0x12345678), then (1, 0xDEADBEEF).
  - Then loadDone=1, cpuHold=0. Extra bytes after this → no writes.
- Bad checksum: same stream with final byte 0x2B → 2 writes, loadError=1, cpuHold=1. Then a full good stream → loadError=0 at magic, loadDone=1.
- Count bounds: A5 00 00 → loadError=1, no writes. A5 01 04 (N=1025) → loadError=1.
- Framing error: stop bit forced 0 on the 3rd data byte → loadError=1, no imWe. Reset asserted mid-word → all outputs at reset values, no imWe.
- With SERIAL_LOADER_TIMEOUT_EN and TIMEOUT_CLKS=10000: A5 01 00 then idle → loadError=1 within 10000 clks of the last stop bit. Without the macro → busy stays 1.
